// File: rtl/serial_adder.sv
// serial_adder: multi-cycle ripple adder, adds DIGIT bits per clock through one
// shared full-adder slice behind a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_acc, w_acc;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [DIGIT:0]   w_slice;
  logic             w_load, w_last, w_cmsb;
  assign w_slice = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_c};
  // carry into the slice MSB recovered from its sum bit and operand bits
  assign w_cmsb  = w_slice[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];
  assign w_acc   = (r_acc >> DIGIT) | (WIDTH'(w_slice[DIGIT-1:0]) << (WIDTH - DIGIT));
  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);
  always_comb begin
    w_last = (r_state == RUN) && (r_cnt == LAST);
    w_load = (r_state != RUN) && start;
    w_next = w_load ? RUN : w_last ? DONE : (r_state == RUN) ? RUN : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_a   <= data_a;
        r_b   <= data_b;
        r_c   <= cin;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_a   <= r_a >> DIGIT;
        r_b   <= r_b >> DIGIT;
        r_c   <= w_slice[DIGIT];
        r_acc <= w_acc;
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_last) begin
        sum      <= w_acc;
        cout     <= w_slice[DIGIT];
        overflow <= w_cmsb ^ w_slice[DIGIT];
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed table vectors on 8-bit instances plus abort,
// back-to-back and exhaustive 3-bit runs, all against hand/model values.
module tb_serial_adder;
  logic       clk = 1'b0, rst_n = 1'b0, cin = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       st [4];
  logic       dn [4], bz [4], co [4], ov [4];
  logic [7:0] sm [4];
  logic [7:0] last_sum [4];
  logic [2:0] s2, s3;
  int         total = 0, pass = 0;
  always #5 clk = ~clk;
  serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (.clk(clk), .rst_n(rst_n), .start(st[0]),
    .data_a(a8), .data_b(b8), .cin(cin), .busy(bz[0]), .done(dn[0]), .sum(sm[0]),
    .cout(co[0]), .overflow(ov[0]));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u1 (.clk(clk), .rst_n(rst_n), .start(st[1]),
    .data_a(a8), .data_b(b8), .cin(cin), .busy(bz[1]), .done(dn[1]), .sum(sm[1]),
    .cout(co[1]), .overflow(ov[1]));
  serial_adder #(.WIDTH(3), .DIGIT(1)) u2 (.clk(clk), .rst_n(rst_n), .start(st[2]),
    .data_a(a8[2:0]), .data_b(b8[2:0]), .cin(cin), .busy(bz[2]), .done(dn[2]), .sum(s2),
    .cout(co[2]), .overflow(ov[2]));
  serial_adder #(.WIDTH(3), .DIGIT(3)) u3 (.clk(clk), .rst_n(rst_n), .start(st[3]),
    .data_a(a8[2:0]), .data_b(b8[2:0]), .cin(cin), .busy(bz[3]), .done(dn[3]), .sum(s3),
    .cout(co[3]), .overflow(ov[3]));
  assign sm[2] = {5'b0, s2};
  assign sm[3] = {5'b0, s3};

  typedef struct {
    int k; logic [7:0] a, b; logic c; logic poke;
    logic [7:0] s; logic co, ov; int lat;
  } vec_t;
  vec_t v [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Called at a negedge; returns at the negedge where done is high (or on abort/timeout).
  task automatic run(input int k, input logic [7:0] a, b, input logic c, input logic poke,
                     input int abort, output int lat, output int bcnt);
    logic held;
    a8 = a; b8 = b; cin = c; st[k] = 1'b1;
    @(negedge clk);
    st[k] = 1'b0; a8 = ~a; b8 = ~b; cin = ~c;
    chk("busy_after_accept", {31'b0, bz[k]}, 1);
    lat = 0; bcnt = 0; held = 1'b1;
    while (!dn[k] && lat < 40) begin
      if (lat == abort) begin
        rst_n = 1'b0;
        #2;
        chk("abort_busy", {31'b0, bz[k]}, 0);
        chk("abort_done", {31'b0, dn[k]}, 0);
        chk("abort_sum", {24'b0, sm[k]}, 0);
        chk("abort_cout_ovf", {30'b0, co[k], ov[k]}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) last_sum[i] = '0;
        return;
      end
      if (poke) begin
        st[k] = (lat == 2);
        a8 = 8'h11; b8 = 8'h11;
      end
      bcnt += int'(bz[k]);
      held &= (sm[k] == last_sum[k]);
      @(negedge clk);
      lat++;
    end
    st[k] = 1'b0;
    chk("sum_held_until_final", {31'b0, held}, 1);
    chk("done_seen", {31'b0, dn[k]}, 1);
  endtask

  task automatic run_chk(input vec_t t);
    int lat, bcnt;
    run(t.k, t.a, t.b, t.c, t.poke, -1, lat, bcnt);
    chk("sum", {24'b0, sm[t.k]}, {24'b0, t.s});
    chk("cout", {31'b0, co[t.k]}, {31'b0, t.co});
    chk("overflow", {31'b0, ov[t.k]}, {31'b0, t.ov});
    chk("latency", lat, t.lat);
    chk("busy_cycles", bcnt, t.lat);
    last_sum[t.k] = t.s;
  endtask

  function automatic vec_t model3(input int k, input logic [2:0] a, b, input logic c);
    vec_t r;
    logic [3:0] f;
    f = {1'b0, a} + {1'b0, b} + {3'b0, c};
    r.k = k; r.a = {5'b0, a}; r.b = {5'b0, b}; r.c = c; r.poke = 1'b0;
    r.s = {5'b0, f[2:0]}; r.co = f[3];
    r.ov = (a[2] == b[2]) && (f[2] != a[2]);
    r.lat = (k == 2) ? 3 : 1;
    return r;
  endfunction

  initial begin
    int lat, bcnt;
    logic seen;
    for (int i = 0; i < 4; i++) begin st[i] = 1'b0; last_sum[i] = '0; end
    v[0] = '{0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 8};
    v[1] = '{0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8};
    v[2] = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 8};
    v[3] = '{0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 8};
    v[4] = '{0, 8'h01, 8'h02, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 8};
    v[5] = '{1, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2};
    v[6] = '{1, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 2};
    v[7] = '{1, 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 2};
    @(negedge clk);
    chk("reset_busy", {31'b0, bz[0]}, 0);
    chk("reset_done", {31'b0, dn[0]}, 0);
    chk("reset_sum", {24'b0, sm[0]}, 0);
    chk("reset_cout_ovf", {30'b0, co[0], ov[0]}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_start", {30'b0, bz[0], dn[0]}, 0);
    for (int i = 0; i < 8; i++) run_chk(v[i]);
    // back-to-back: start issued in the DONE cycle of the previous operation
    run_chk('{0, 8'h22, 8'h33, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 8});
    // abort mid-run, then a clean operation afterwards
    run(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 4, lat, bcnt);
    seen = 1'b0;
    repeat (12) begin @(negedge clk); seen |= dn[0] | bz[0]; end
    chk("no_done_after_abort", {31'b0, seen}, 0);
    run_chk('{0, 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 8});
    for (int k = 2; k < 4; k++)
      for (int i = 0; i < 128; i++)
        run_chk(model3(k, 3'(i >> 4), 3'(i >> 1), i[0]));
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
